// File: rtl/bicount_decoder.sv
// Decodes successive samples of a bidirectional mod-MODULUS counter into up/down steps,
// tracks a saturating signed net position and latches illegal-transition faults.
module bicount_decoder #(
    parameter int MODULUS = 11,
    parameter int CW      = 4,
    parameter int POSW    = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    input  logic [CW-1:0]          IN_COUNT,
    input  logic                   CLR_ERR,
    output logic                   STEP_UP,
    output logic                   STEP_DN,
    output logic                   WRAP_UP,
    output logic                   WRAP_DN,
    output logic                   DIR_OUT,
    output logic                   MOVING,
    output logic signed [POSW-1:0] POSITION,
    output logic                   ERR,
    output logic [1:0]             ERR_CODE,
    output logic [1:0]             STATE
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCKED   = 2'b01,
        FAULT    = 2'b10
    } state_t;

    localparam logic [CW-1:0] MAXC = CW'(MODULUS - 1);
    localparam logic signed [POSW-1:0] POS_MAX = {1'b0, {(POSW-1){1'b1}}};
    localparam logic signed [POSW-1:0] POS_MIN = {1'b1, {(POSW-1){1'b0}}};
    localparam logic signed [POSW-1:0] POS_ONE = $signed(POSW'(1));

    function automatic logic signed [POSW-1:0] sat_inc(input logic signed [POSW-1:0] v);
        return (v == POS_MAX) ? v : v + POS_ONE;
    endfunction

    function automatic logic signed [POSW-1:0] sat_dec(input logic signed [POSW-1:0] v);
        return (v == POS_MIN) ? v : v - POS_ONE;
    endfunction

    state_t                 state, state_nx;
    logic [CW-1:0]          prev, prev_nx;
    logic                   step_up_nx, step_dn_nx, wrap_up_nx, wrap_dn_nx;
    logic                   dir_nx, moving_nx, err_nx;
    logic [1:0]             err_code_nx;
    logic signed [POSW-1:0] pos_nx;
    logic [CW-1:0]          up_val, dn_val;
    logic                   out_of_range;

    assign up_val       = (prev == MAXC) ? '0 : prev + CW'(1);
    assign dn_val       = (prev == '0) ? MAXC : prev - CW'(1);
    assign out_of_range = (IN_COUNT > MAXC);

    always_comb begin
        state_nx    = state;
        prev_nx     = prev;
        step_up_nx  = 1'b0;
        step_dn_nx  = 1'b0;
        wrap_up_nx  = 1'b0;
        wrap_dn_nx  = 1'b0;
        dir_nx      = DIR_OUT;
        moving_nx   = MOVING;
        pos_nx      = POSITION;
        err_nx      = ERR;
        err_code_nx = ERR_CODE;
        case (state)
            UNLOCKED: begin
                if (IN_VALID) begin
                    moving_nx = 1'b0;
                    if (out_of_range) begin
                        err_nx      = 1'b1;
                        err_code_nx = 2'b01;
                        state_nx    = FAULT;
                    end else begin
                        prev_nx  = IN_COUNT;
                        state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (IN_VALID) begin
                    moving_nx = 1'b0;
                    if (out_of_range) begin
                        err_nx      = 1'b1;
                        err_code_nx = 2'b01;
                        state_nx    = FAULT;
                    end else if (IN_COUNT == prev) begin
                        prev_nx = IN_COUNT;
                    // Up is tested first so that MODULUS==2 (UP==DN) decodes as up.
                    end else if (IN_COUNT == up_val) begin
                        prev_nx    = IN_COUNT;
                        step_up_nx = 1'b1;
                        wrap_up_nx = (prev == MAXC);
                        dir_nx     = 1'b1;
                        moving_nx  = 1'b1;
                        pos_nx     = sat_inc(POSITION);
                    end else if (IN_COUNT == dn_val) begin
                        prev_nx    = IN_COUNT;
                        step_dn_nx = 1'b1;
                        wrap_dn_nx = (prev == '0);
                        dir_nx     = 1'b0;
                        moving_nx  = 1'b1;
                        pos_nx     = sat_dec(POSITION);
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = 2'b10;
                        state_nx    = FAULT;
                    end
                end
            end
            FAULT: begin
                moving_nx = 1'b0;
                if (CLR_ERR) begin
                    err_nx      = 1'b0;
                    err_code_nx = 2'b00;
                    pos_nx      = '0;
                    state_nx    = UNLOCKED;
                end
            end
            default: state_nx = UNLOCKED;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= UNLOCKED;
            prev     <= '0;
            STEP_UP  <= 1'b0;
            STEP_DN  <= 1'b0;
            WRAP_UP  <= 1'b0;
            WRAP_DN  <= 1'b0;
            DIR_OUT  <= 1'b1;
            MOVING   <= 1'b0;
            POSITION <= '0;
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
        end else begin
            state    <= state_nx;
            prev     <= prev_nx;
            STEP_UP  <= step_up_nx;
            STEP_DN  <= step_dn_nx;
            WRAP_UP  <= wrap_up_nx;
            WRAP_DN  <= wrap_dn_nx;
            DIR_OUT  <= dir_nx;
            MOVING   <= moving_nx;
            POSITION <= pos_nx;
            ERR      <= err_nx;
            ERR_CODE <= err_code_nx;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_bicount_decoder.sv
// Directed bench for bicount_decoder: a POSW=16 instance for normal decoding and a
// POSW=4 instance sharing the same stimulus for the saturation scenario.
module tb_bicount_decoder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [3:0]  IN_COUNT = '0;
    logic        CLR_ERR = 1'b0;

    logic        step_up, step_dn, wrap_up, wrap_dn, dir_out, moving, err;
    logic [1:0]  err_code, state;
    logic signed [15:0] position;

    logic        s_step_up, s_step_dn, s_wrap_up, s_wrap_dn, s_dir_out, s_moving, s_err;
    logic [1:0]  s_err_code, s_state;
    logic signed [3:0] s_position;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bicount_decoder #(.MODULUS(11), .CW(4), .POSW(16)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_COUNT(IN_COUNT), .CLR_ERR(CLR_ERR),
        .STEP_UP(step_up), .STEP_DN(step_dn), .WRAP_UP(wrap_up), .WRAP_DN(wrap_dn),
        .DIR_OUT(dir_out), .MOVING(moving), .POSITION(position), .ERR(err),
        .ERR_CODE(err_code), .STATE(state)
    );

    bicount_decoder #(.MODULUS(11), .CW(4), .POSW(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_COUNT(IN_COUNT), .CLR_ERR(CLR_ERR),
        .STEP_UP(s_step_up), .STEP_DN(s_step_dn), .WRAP_UP(s_wrap_up), .WRAP_DN(s_wrap_dn),
        .DIR_OUT(s_dir_out), .MOVING(s_moving), .POSITION(s_position), .ERR(s_err),
        .ERR_CODE(s_err_code), .STATE(s_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic v, input logic [3:0] c, input logic clr);
        IN_VALID = v;
        IN_COUNT = c;
        CLR_ERR  = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, step_up, step_dn, wrap_up, wrap_dn}, {28'd0, exp});
    endtask

    initial begin
        // Reset
        RESET = 1'b0;
        cyc(1'b1, 4'd7, 1'b0);
        chk("rst_state", state, 2'b00);
        chk_pulses("rst_pulses", 4'b0000);
        chk("rst_dir", dir_out, 1'b1);
        chk("rst_moving", moving, 1'b0);
        chk("rst_pos", position, 16'd0);
        chk("rst_err", {err, err_code}, 3'b000);
        RESET = 1'b1;

        // 1: lock on 3, two up steps
        cyc(1'b1, 4'd3, 1'b0);
        chk("t1_lock_state", state, 2'b01);
        chk_pulses("t1_lock_pulses", 4'b0000);
        cyc(1'b1, 4'd4, 1'b0);
        chk_pulses("t1_up4", 4'b1000);
        cyc(1'b1, 4'd5, 1'b0);
        chk_pulses("t1_up5", 4'b1000);
        chk("t1_pos", position, 16'd2);
        chk("t1_dir", dir_out, 1'b1);
        cyc(1'b0, 4'd9, 1'b0);
        chk_pulses("t1_idle_pulses", 4'b0000);
        chk("t1_idle_moving", moving, 1'b1);
        chk("t1_idle_pos", position, 16'd2);

        // 2: walk to 9, then 10 and wrap to 0
        for (int i = 6; i <= 9; i++) cyc(1'b1, 4'(i), 1'b0);
        chk("t2_pos9", position, 16'd6);
        cyc(1'b1, 4'd10, 1'b0);
        chk_pulses("t2_up10", 4'b1000);
        cyc(1'b1, 4'd0, 1'b0);
        chk_pulses("t2_wrap0", 4'b1010);
        chk("t2_pos", position, 16'd8);

        // 3: from 1, down through 0, 10, 9
        cyc(1'b1, 4'd1, 1'b0);
        chk("t3_pos1", position, 16'd9);
        cyc(1'b1, 4'd0, 1'b0);
        chk_pulses("t3_dn0", 4'b0100);
        cyc(1'b1, 4'd10, 1'b0);
        chk_pulses("t3_wrapdn", 4'b0101);
        cyc(1'b1, 4'd9, 1'b0);
        chk_pulses("t3_dn9", 4'b0100);
        chk("t3_dir", dir_out, 1'b0);
        chk("t3_pos", position, 16'd6);
        cyc(1'b1, 4'd9, 1'b0);
        chk("t3_hold_moving", moving, 1'b0);
        chk_pulses("t3_hold_pulses", 4'b0000);

        // 4: skipped value faults; CLR_ERR clears and zeroes position
        RESET = 1'b0;
        cyc(1'b0, 4'd0, 1'b0);
        RESET = 1'b1;
        cyc(1'b1, 4'd3, 1'b0);
        cyc(1'b1, 4'd4, 1'b0);
        chk("t4_pos1", position, 16'd1);
        cyc(1'b1, 4'd6, 1'b0);
        chk("t4_err", {err, err_code}, 3'b110);
        chk("t4_state", state, 2'b10);
        cyc(1'b1, 4'd7, 1'b0);
        chk_pulses("t4_fault_pulses", 4'b0000);
        chk("t4_fault_pos", position, 16'd1);
        chk("t4_fault_moving", moving, 1'b0);
        cyc(1'b0, 4'd0, 1'b1);
        chk("t4_clr_state", state, 2'b00);
        chk("t4_clr_err", {err, err_code}, 3'b000);
        chk("t4_clr_pos", position, 16'd0);

        // 5: out-of-range while UNLOCKED and while LOCKED
        cyc(1'b1, 4'd12, 1'b0);
        chk("t5_unl_err", {err, err_code}, 3'b101);
        chk("t5_unl_state", state, 2'b10);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd5, 1'b0);
        chk("t5_lock", state, 2'b01);
        cyc(1'b1, 4'd12, 1'b0);
        chk("t5_lck_err", {err, err_code}, 3'b101);
        chk("t5_lck_state", state, 2'b10);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd12, 1'b0);
        chk("t5_inv_state", state, 2'b00);
        chk("t5_inv_err", err, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        cyc(1'b1, 4'd6, 1'b1);
        chk("t5_clr_noeffect", state, 2'b01);
        chk_pulses("t5_clr_step", 4'b1000);

        // 6: POSW=4 saturation at +7, then reset mid-run
        RESET = 1'b0;
        cyc(1'b0, 4'd0, 1'b0);
        RESET = 1'b1;
        cyc(1'b1, 4'd0, 1'b0);
        for (int i = 1; i <= 7; i++) cyc(1'b1, 4'(i), 1'b0);
        chk("t6_pos7", {28'd0, s_position}, 32'd7);
        cyc(1'b1, 4'd8, 1'b0);
        cyc(1'b1, 4'd9, 1'b0);
        chk("t6_sat_pos", {28'd0, s_position}, 32'd7);
        chk("t6_sat_step", s_step_up, 1'b1);
        cyc(1'b1, 4'd10, 1'b0);
        cyc(1'b1, 4'd0, 1'b0);
        chk("t6_sat_wrap", {s_step_up, s_wrap_up}, 2'b11);
        chk("t6_sat_err", s_err, 1'b0);
        chk("t6_wide_pos", position, 16'd11);
        RESET = 1'b0;
        cyc(1'b1, 4'd1, 1'b0);
        chk("t6_rst_state", s_state, 2'b00);
        chk("t6_rst_pulses", {s_step_up, s_step_dn, s_wrap_up, s_wrap_dn}, 4'b0000);
        chk("t6_rst_pos", {28'd0, s_position}, 32'd0);
        chk("t6_rst_dir_mov", {s_dir_out, s_moving}, 2'b10);
        chk("t6_rst_wide_pos", position, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
